program_sequencer: RTL and testbench

Instruction feeder for the 9-bit processor's control unit: holds a small program in a register-array store, drives the processor's `DIN` bus and `run` input, and advances on the processor's `done` pulse. It handles the processor's two-word MVI format by presenting the immediate word in the step after the opcode. It stops on a reserved HALT opcode. It sits between a host or test loader and the processor datapath, on the opposite side of the run/done handshake from the control unit.

---
 rtl/program_sequencer.sv | 179 +++++++++++++++++
 tb/tb_program_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: feeds a small stored program to the 9-bit processor over
// its DIN/run/done handshake. MVI is presented as two words (opcode, then
// immediate). Execution stops on the HALT opcode (111), which is never sent.
// Optional watchdog: define PSEQ_WATCHDOG_EN to build it; otherwise wd_err_o is 0.
module program_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned WD_LIMIT = 8
) (
  input  logic          clock_i,
  input  logic          resetn_i,
  input  logic          load_en_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [8:0]    load_data_i,
  input  logic          start_i,
  input  logic          done_i,
  output logic [8:0]    din_o,
  output logic          run_o,
  output logic          busy_o,
  output logic          halted_o,
  output logic [AW-1:0] pc_o,
  output logic [7:0]    retired_o,
  output logic          wd_err_o
);

  localparam logic [2:0] OpMvi  = 3'b100;
  localparam logic [2:0] OpHalt = 3'b111;

  if (DEPTH != (1 << AW)) begin : g_chk_depth
    $error("DEPTH must equal 2**AW");
  end
  if (WD_LIMIT == 0) begin : g_chk_wd
    $error("WD_LIMIT must be non-zero");
  end

  typedef enum logic [2:0] {StIdle, StFetch, StImm, StWait, StHalted} state_e;

  state_e        state_q, state_d;
  logic [8:0]    din_q, din_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    retired_q, retired_d;
  logic [8:0]    mem_q [DEPTH];

  logic          stopped;
  logic          busy;
  logic          mem_we;
  logic [8:0]    word0;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_next;
  logic [8:0]    next_word;

  assign stopped = (state_q == StIdle) || (state_q == StHalted);
  assign busy    = (state_q == StFetch) || (state_q == StImm) || (state_q == StWait);
  assign mem_we  = load_en_i && stopped;

  // Store is writable only while stopped; no reset so contents survive resetn.
  always_ff @(posedge clock_i) begin
    if (mem_we) mem_q[load_addr_i] <= load_data_i;
  end

  // Address/word helpers; a same-edge write to address 0 is forwarded to start.
  always_comb begin
    word0     = (mem_we && (load_addr_i == '0)) ? load_data_i : mem_q[0];
    pc_inc    = pc_q + AW'(1);
    pc_next   = (mem_q[pc_q][8:6] == OpMvi) ? pc_q + AW'(2) : pc_inc;
    next_word = mem_q[pc_next];
  end

`ifdef PSEQ_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WD_LIMIT + 1);
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_err_q, wd_err_d;
`endif

  // Next-state logic for the sequencing FSM and its datapath registers.
  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    pc_d      = pc_q;
    retired_d = retired_q;
`ifdef PSEQ_WATCHDOG_EN
    wd_cnt_d  = wd_cnt_q;
    wd_err_d  = wd_err_q;
`endif
    unique case (state_q)
      StIdle, StHalted: begin
        if (start_i) begin
          pc_d      = '0;
          retired_d = '0;
          if (word0[8:6] == OpHalt) begin
            state_d = StHalted;
            din_d   = '0;
          end else begin
            state_d = StFetch;
            din_d   = word0;
          end
        end
      end
      StFetch: begin
        if (din_q[8:6] == OpMvi) begin
          state_d = StImm;
          din_d   = mem_q[pc_inc];
        end else begin
          state_d = StWait;
        end
      end
      StImm: state_d = StWait;
      StWait: begin
        if (done_i) begin
          pc_d      = pc_next;
          retired_d = (retired_q == 8'hFF) ? retired_q : retired_q + 8'd1;
          if (next_word[8:6] == OpHalt) begin
            state_d = StHalted;
            din_d   = '0;
          end else begin
            state_d = StFetch;
            din_d   = next_word;
          end
        end
      end
      default: begin
        state_d = StIdle;
        din_d   = '0;
      end
    endcase
`ifdef PSEQ_WATCHDOG_EN
    if (stopped && start_i) wd_err_d = 1'b0;
    // Entering FETCH restarts the count; a completing done never trips it.
    if (state_d == StFetch) begin
      wd_cnt_d = '0;
    end else if (busy && !((state_q == StWait) && done_i)) begin
      if (wd_cnt_q == WdW'(WD_LIMIT - 1)) begin
        wd_err_d = 1'b1;
        state_d  = StHalted;
        din_d    = '0;
        wd_cnt_d = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + WdW'(1);
      end
    end
`endif
  end

  // State registers; reset drops run and clears din immediately.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= StIdle;
      din_q     <= '0;
      pc_q      <= '0;
      retired_q <= '0;
`ifdef PSEQ_WATCHDOG_EN
      wd_cnt_q  <= '0;
      wd_err_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
`ifdef PSEQ_WATCHDOG_EN
      wd_cnt_q  <= wd_cnt_d;
      wd_err_q  <= wd_err_d;
`endif
    end
  end

  assign din_o     = din_q;
  assign run_o     = busy;
  assign busy_o    = busy;
  assign halted_o  = (state_q == StHalted);
  assign pc_o      = pc_q;
  assign retired_o = retired_q;
`ifdef PSEQ_WATCHDOG_EN
  assign wd_err_o  = wd_err_q;
`else
  assign wd_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: vector table plus hand-written
// sequences for wrap-around, busy-time ignores, async reset and saturation.
module tb_program_sequencer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [8:0] load_data = '0;
  logic       start = 1'b0;
  logic       done = 1'b0;
  logic [8:0] din;
  logic       run, busy, halted, wd_err;
  logic [3:0] pc;
  logic [7:0] retired;

  int checks = 0;
  int failures = 0;

  program_sequencer #(.DEPTH(16), .AW(4), .WD_LIMIT(8)) dut (
    .clock_i    (clock),
    .resetn_i   (resetn),
    .load_en_i  (load_en),
    .load_addr_i(load_addr),
    .load_data_i(load_data),
    .start_i    (start),
    .done_i     (done),
    .din_o      (din),
    .run_o      (run),
    .busy_o     (busy),
    .halted_o   (halted),
    .pc_o       (pc),
    .retired_o  (retired),
    .wd_err_o   (wd_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       le;
    logic [3:0] la;
    logic [8:0] ld;
    logic       st;
    logic       dn;
    logic [8:0] din;
    logic       run;
    logic       halted;
    logic [3:0] pc;
    logic [7:0] ret;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic le, input logic [3:0] la, input logic [8:0] ld,
                              input logic st, input logic dn, input logic [8:0] edin,
                              input logic erun, input logic ehalt, input logic [3:0] epc,
                              input logic [7:0] eret);
    vec_t v;
    v.le = le; v.la = la; v.ld = ld; v.st = st; v.dn = dn;
    v.din = edin; v.run = erun; v.halted = ehalt; v.pc = epc; v.ret = eret;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [8:0] edin, input logic erun,
                         input logic ehalt, input logic [3:0] epc, input logic [7:0] eret);
    chk({nm, ".din"}, din, edin);
    chk({nm, ".run"}, run, erun);
    chk({nm, ".busy"}, busy, erun);
    chk({nm, ".halted"}, halted, ehalt);
    chk({nm, ".pc"}, pc, epc);
    chk({nm, ".retired"}, retired, eret);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic st, input logic dn);
    load_en = 1'b0; start = st; done = dn;
    tick();
    start = 1'b0; done = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [8:0] d);
    load_en = 1'b1; load_addr = a; load_data = d; start = 1'b0; done = 1'b0;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    // Program 1: MVI R0,#5; MV R1,R0; HALT.
    vecs[0]  = mk(1, 0, 9'h100, 0, 0, 9'h000, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 9'h005, 0, 0, 9'h000, 0, 0, 0, 0);
    vecs[2]  = mk(1, 2, 9'h048, 0, 0, 9'h000, 0, 0, 0, 0);
    vecs[3]  = mk(1, 3, 9'h1C0, 0, 0, 9'h000, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 9'h000, 1, 0, 9'h100, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 9'h000, 0, 0, 9'h005, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 9'h000, 0, 0, 9'h005, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 9'h000, 0, 1, 9'h048, 1, 0, 2, 1);
    vecs[8]  = mk(0, 0, 9'h000, 0, 0, 9'h048, 1, 0, 2, 1);
    vecs[9]  = mk(0, 0, 9'h000, 0, 0, 9'h048, 1, 0, 2, 1);
    vecs[10] = mk(0, 0, 9'h000, 0, 1, 9'h000, 0, 1, 3, 2);
    vecs[11] = mk(0, 0, 9'h000, 0, 1, 9'h000, 0, 1, 3, 2);
    // Program 2 loaded while halted: ADD; NOP; HALT.
    vecs[12] = mk(1, 0, 9'h081, 0, 0, 9'h000, 0, 1, 3, 2);
    vecs[13] = mk(1, 1, 9'h000, 0, 0, 9'h000, 0, 1, 3, 2);
    vecs[14] = mk(1, 2, 9'h1C0, 0, 0, 9'h000, 0, 1, 3, 2);
    vecs[15] = mk(0, 0, 9'h000, 1, 0, 9'h081, 1, 0, 0, 0);
    vecs[16] = mk(0, 0, 9'h000, 0, 0, 9'h081, 1, 0, 0, 0);
    vecs[17] = mk(0, 0, 9'h000, 0, 0, 9'h081, 1, 0, 0, 0);
    vecs[18] = mk(0, 0, 9'h000, 0, 0, 9'h081, 1, 0, 0, 0);
    vecs[19] = mk(0, 0, 9'h000, 0, 1, 9'h000, 1, 0, 1, 1);
    vecs[20] = mk(0, 0, 9'h000, 0, 0, 9'h000, 1, 0, 1, 1);
    vecs[21] = mk(0, 0, 9'h000, 0, 1, 9'h000, 0, 1, 2, 2);

    // Reset values.
    #2;
    chk_out("reset", 9'h000, 1'b0, 1'b0, 4'd0, 8'd0);
    chk("reset.wd_err", wd_err, 0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      load_en = vecs[i].le; load_addr = vecs[i].la; load_data = vecs[i].ld;
      start = vecs[i].st; done = vecs[i].dn;
      tick();
      chk_out($sformatf("v%0d", i), vecs[i].din, vecs[i].run, vecs[i].halted,
              vecs[i].pc, vecs[i].ret);
    end
    load_en = 1'b0; start = 1'b0; done = 1'b0;

    // MVI at address 15 with its immediate at address 0; busy-time load/start ignored.
    do_reset();
    load(4'd0, 9'h02A);
    for (int a = 1; a < 15; a++) load(4'(a), 9'h000);
    load(4'd15, 9'h100);
    step(1'b1, 1'b0);
    chk_out("wrap.first", 9'h02A, 1'b1, 1'b0, 4'd0, 8'd0);
    for (int n = 0; n < 15; n++) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    chk_out("wrap.fetch15", 9'h100, 1'b1, 1'b0, 4'd15, 8'd15);
    load_en = 1'b1; load_addr = 4'd1; load_data = 9'h1FF; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    chk_out("wrap.imm", 9'h02A, 1'b1, 1'b0, 4'd15, 8'd15);
    step(1'b0, 1'b0);
    chk_out("wrap.wait", 9'h02A, 1'b1, 1'b0, 4'd15, 8'd15);
    step(1'b0, 1'b1);
    chk_out("wrap.after", 9'h000, 1'b1, 1'b0, 4'd1, 8'd16);

    // Asynchronous reset during WAIT of an ADD, then re-run from 0.
    do_reset();
    load(4'd0, 9'h081);
    load(4'd1, 9'h000);
    load(4'd2, 9'h1C0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk_out("rst.wait", 9'h081, 1'b1, 1'b0, 4'd0, 8'd0);
    resetn = 1'b0;
    #1;
    chk_out("rst.async", 9'h000, 1'b0, 1'b0, 4'd0, 8'd0);
    #1;
    resetn = 1'b1;
    step(1'b1, 1'b0);
    chk_out("rst.rerun", 9'h081, 1'b1, 1'b0, 4'd0, 8'd0);

    // Write to address 0 on the same edge as start is seen by the first fetch.
    do_reset();
    load_en = 1'b1; load_addr = 4'd0; load_data = 9'h0C0; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    chk_out("fwd.sub", 9'h0C0, 1'b1, 1'b0, 4'd0, 8'd0);
    do_reset();
    load_en = 1'b1; load_addr = 4'd0; load_data = 9'h1C0; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    chk_out("fwd.halt", 9'h000, 1'b0, 1'b1, 4'd0, 8'd0);

    // Retired count saturates at 255.
    do_reset();
    for (int a = 0; a < 16; a++) load(4'(a), 9'h000);
    step(1'b1, 1'b0);
    for (int n = 0; n < 260; n++) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    chk_out("sat", 9'h000, 1'b1, 1'b0, 4'd4, 8'd255);

`ifdef PSEQ_WATCHDOG_EN
    // Watchdog: done withheld after the MV is fetched.
    do_reset();
    load(4'd0, 9'h100);
    load(4'd1, 9'h005);
    load(4'd2, 9'h048);
    load(4'd3, 9'h1C0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk_out("wd.fetch", 9'h048, 1'b1, 1'b0, 4'd2, 8'd1);
    repeat (7) step(1'b0, 1'b0);
    chk("wd.pre.busy", busy, 1);
    chk("wd.pre.err", wd_err, 0);
    step(1'b0, 1'b0);
    chk_out("wd.trip", 9'h000, 1'b0, 1'b1, 4'd2, 8'd1);
    chk("wd.trip.err", wd_err, 1);
    step(1'b1, 1'b0);
    chk("wd.clear", wd_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
